pdm_playback_controller: RTL and testbench

Playback side of the microphone recording path. Reads the 32-bit PDM words the recorder stored in BRAM, at word addresses `{1'b1, idx[9:0], 5'b00000}`. Serialises them MSB-first to the audio PDM output, one bit per `BIT_CYCLES` system clocks, which is the recorder's sampling rate. A prefetch buffer keeps the bitstream gap-free across word boundaries; the block sits beside the recorder on the shared BRAM port, on the `clkout_sys` clock.

---
 rtl/pdm_playback_controller.sv | 187 ++++++++++++++++++
 tb/tb_pdm_playback_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_playback_controller.sv
// PDM playback: streams recorded 32-bit BRAM words MSB-first to the audio pin.
// A one-word prefetch keeps the bitstream gap-free across word boundaries.
module pdm_playback_controller #(
  parameter int BIT_CYCLES = 100,
  parameter int NUM_WORDS  = 937,
  parameter int RD_LAT     = 2
) (
  input  logic        clkout_sys,
  input  logic        reset,
  input  logic        play_button,
  input  logic        stop_button,
  output logic        bram_enable,
  output logic [3:0]  bram_wea,
  output logic [15:0] bram_addr,
  input  logic [31:0] bram_data_out,
  output logic        audio_pwm,
  output logic        audio_sd,
  output logic        busy,
  output logic        done
);

  localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [TW-1:0] T_LAST  = TW'(BIT_CYCLES - 1);
  localparam logic [LW-1:0] W_LAST  = LW'(RD_LAT - 1);
  localparam logic [10:0]   NW      = 11'(NUM_WORDS);
  localparam logic [9:0]    WP_LAST = 10'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    PLAY,
    DONE
  } state_t;

  state_t        state_q;
  logic          btn_q;
  logic [9:0]    idx_q;
  logic [9:0]    words_q;
  logic [31:0]   shift_q;
  logic [31:0]   next_q;
  logic [TW-1:0] timer_q;
  logic [4:0]    bit_q;
  logic [LW-1:0] wait_q;
  logic [LW-1:0] pf_q;
  logic          pf_act_q;
  logic          en_q;
  logic          pwm_q;
  logic          sd_q;
  logic          busy_q;
  logic          done_q;

  logic start_d;
  logic t_end_d;
  logic w_end_d;
  logic issue_d;

  assign start_d = play_button & ~btn_q;
  assign t_end_d = (timer_q == T_LAST);
  assign w_end_d = t_end_d && (bit_q == 5'd31);
  assign issue_d = ({1'b0, idx_q} < NW);

  assign bram_enable = en_q;
  assign bram_wea    = 4'b0000;
  assign bram_addr   = {1'b1, idx_q, 5'b00000};
  assign audio_pwm   = pwm_q;
  assign audio_sd    = sd_q;
  assign busy        = busy_q;
  assign done        = done_q;

  always_ff @(posedge clkout_sys or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      btn_q    <= 1'b0;
      idx_q    <= '0;
      words_q  <= '0;
      shift_q  <= '0;
      next_q   <= '0;
      timer_q  <= '0;
      bit_q    <= '0;
      wait_q   <= '0;
      pf_q     <= '0;
      pf_act_q <= 1'b0;
      en_q     <= 1'b0;
      pwm_q    <= 1'b0;
      sd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      btn_q  <= play_button;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          idx_q    <= '0;
          en_q     <= 1'b0;
          pwm_q    <= 1'b0;
          sd_q     <= 1'b0;
          pf_act_q <= 1'b0;
          if (start_d) begin
            state_q <= PRIME;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            wait_q  <= '0;
          end
        end
        PRIME: begin
          if (stop_button) begin
            state_q <= IDLE;
            idx_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else if (wait_q == W_LAST) begin
            state_q  <= PLAY;
            shift_q  <= bram_data_out;
            pwm_q    <= bram_data_out[31];
            sd_q     <= 1'b1;
            idx_q    <= 10'd1;
            words_q  <= '0;
            bit_q    <= '0;
            timer_q  <= '0;
            pf_q     <= '0;
            // Word 1 is fetched during the first cycles of word 0.
            en_q     <= (NW > 11'd1);
            pf_act_q <= (NW > 11'd1);
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        PLAY: begin
          if (stop_button) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            en_q     <= 1'b0;
            pf_act_q <= 1'b0;
            pwm_q    <= 1'b0;
            sd_q     <= 1'b0;
            busy_q   <= 1'b0;
          end else begin
            if (pf_act_q) begin
              if (pf_q == W_LAST) begin
                next_q   <= bram_data_out;
                idx_q    <= idx_q + 1'b1;
                en_q     <= 1'b0;
                pf_act_q <= 1'b0;
              end else begin
                pf_q <= pf_q + 1'b1;
              end
            end
            if (t_end_d) begin
              timer_q <= '0;
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q << 1;
              pwm_q   <= shift_q[30];
              if (w_end_d) begin
                if (words_q == WP_LAST) begin
                  state_q  <= DONE;
                  done_q   <= 1'b1;
                  pwm_q    <= 1'b0;
                  sd_q     <= 1'b0;
                  en_q     <= 1'b0;
                  pf_act_q <= 1'b0;
                end else begin
                  shift_q <= next_q;
                  pwm_q   <= next_q[31];
                  words_q <= words_q + 1'b1;
                  if (issue_d) begin
                    en_q     <= 1'b1;
                    pf_act_q <= 1'b1;
                    pf_q     <= '0;
                  end
                end
              end
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          idx_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_playback_controller.sv
// Directed bench for pdm_playback_controller at BIT_CYCLES=4, NUM_WORDS=3.
// Per-cycle captures are compared against hand-derived stream timing.
module tb_pdm_playback_controller;

  localparam int BC  = 4;
  localparam int NWD = 3;
  localparam int RL  = 2;
  localparam int P0  = 1 + RL - 1;
  localparam int LEN = NWD * 32 * BC;
  localparam int CAP = P0 + LEN + 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play = 1'b0;
  logic        stop = 1'b0;
  logic        en;
  logic [3:0]  wea;
  logic [15:0] addr;
  logic [31:0] rd;
  logic        pwm, sd, busy, done;

  pdm_playback_controller #(
    .BIT_CYCLES(BC),
    .NUM_WORDS(NWD),
    .RD_LAT(RL)
  ) dut (
    .clkout_sys(clk),
    .reset(reset),
    .play_button(play),
    .stop_button(stop),
    .bram_enable(en),
    .bram_wea(wea),
    .bram_addr(addr),
    .bram_data_out(rd),
    .audio_pwm(pwm),
    .audio_sd(sd),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  logic [31:0] words [0:2];

  // Two-cycle BRAM: address cycle, then data visible for the capture edge.
  always @(posedge clk) if (en) rd <= mem[addr[14:5]];

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic        pwm_a  [0:CAP-1];
  logic        sd_a   [0:CAP-1];
  logic        en_a   [0:CAP-1];
  logic        done_a [0:CAP-1];
  logic        busy_a [0:CAP-1];
  logic [15:0] addr_a [0:CAP-1];
  logic [3:0]  wea_a  [0:CAP-1];

  task automatic sample(input int k);
    pwm_a[k]  = pwm;
    sd_a[k]   = sd;
    en_a[k]   = en;
    done_a[k] = done;
    busy_a[k] = busy;
    addr_a[k] = addr;
    wea_a[k]  = wea;
  endtask

  task automatic capture(input int from, input int to);
    for (int k = from; k < to; k++) begin
      @(negedge clk);
      sample(k);
    end
  endtask

  task automatic pulse_play(input bit hold);
    @(negedge clk);
    play = 1'b1;
    @(negedge clk);
    sample(0);
    if (!hold) play = 1'b0;
  endtask

  function automatic logic expbit(input int k);
    int w, b;
    logic [31:0] wd;
    w  = (k - P0) / (32 * BC);
    b  = ((k - P0) / BC) % 32;
    wd = words[w];
    return wd[31-b];
  endfunction

  task automatic check_take(input string tg);
    int bad, sdn, first, donek, donen, bfall, enn, wbad;
    logic [31:0] rec, got, exp;
    int ek [0:5];
    logic [15:0] ea [0:5];
    logic e;
    ek = '{0, 1, 2, 3, P0 + 128, P0 + 129};
    ea = '{16'h8000, 16'h8000, 16'h8020, 16'h8020, 16'h8040, 16'h8040};
    bad = 0; sdn = 0; first = -1; donek = -1; donen = 0;
    bfall = -1; enn = 0; wbad = 0;
    for (int k = 0; k < CAP; k++) begin
      e = (k >= P0 && k < P0 + LEN) ? expbit(k) : 1'b0;
      if (pwm_a[k] !== e) bad++;
      if (sd_a[k]) begin
        sdn++;
        if (first < 0) first = k;
      end
      if (done_a[k]) begin
        donen++;
        if (donek < 0) donek = k;
      end
      if (donek >= 0 && bfall < 0 && !busy_a[k]) bfall = k;
      if (wea_a[k] !== 4'b0000) wbad++;
      if (en_a[k]) begin
        if (enn < 6) begin
          got = {16'(k), addr_a[k]};
          exp = {16'(ek[enn]), ea[enn]};
          chk($sformatf("%s_rd%0d", tg, enn), got, exp);
        end
        enn++;
      end
    end
    for (int w = 0; w < NWD; w++) begin
      rec = '0;
      for (int b = 0; b < 32; b++)
        rec[31-b] = pwm_a[P0 + 128*w + BC*b + BC/2];
      chk($sformatf("%s_word%0d", tg, w), rec, words[w]);
    end
    chk({tg, "_prime_busy"}, 32'(busy_a[0]), 32'd1);
    chk({tg, "_pwm_cycles"}, bad, 0);
    chk({tg, "_play_start"}, first, P0);
    chk({tg, "_play_len"}, sdn, LEN);
    chk({tg, "_done_at"}, donek, P0 + LEN);
    chk({tg, "_done_cnt"}, donen, 1);
    chk({tg, "_busy_fall"}, bfall, P0 + LEN + 1);
    chk({tg, "_rd_cnt"}, enn, 6);
    chk({tg, "_wea"}, wbad, 0);
  endtask

  task automatic chk_idle(input string tg);
    chk({tg, "_outs"}, {28'd0, pwm, sd, busy, done}, 32'd0);
    chk({tg, "_en"}, 32'(en), 32'd0);
    chk({tg, "_addr"}, 32'(addr), 32'h8000);
  endtask

  int cnt;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    words = '{32'h80000001, 32'hAAAAAAAA, 32'h0000FFFF};
    for (int i = 0; i < NWD; i++) mem[i] = words[i];

    repeat (3) @(negedge clk);
    chk_idle("rst_hold");
    chk("rst_wea", 32'(wea), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("rst_rel");

    // Single pulse: full take
    pulse_play(1'b0);
    capture(1, CAP);
    check_take("t1");

    // Held button: one take only
    pulse_play(1'b1);
    capture(1, CAP);
    check_take("t3");
    capture(0, 40);
    cnt = 0;
    for (int k = 0; k < 40; k++) if (busy_a[k]) cnt++;
    chk("t3_no_restart", cnt, 0);
    @(negedge clk);
    play = 1'b0;
    repeat (2) @(negedge clk);

    // Stop at bit 10 of word 1
    pulse_play(1'b0);
    capture(1, P0 + 128 + 40 + 1);
    chk("t4_bit10", 32'(pwm), 32'(expbit(P0 + 128 + 40)));
    stop = 1'b1;
    @(negedge clk);
    chk_idle("t4_stop");
    stop = 1'b0;
    capture(0, 30);
    cnt = 0;
    for (int k = 0; k < 30; k++) if (done_a[k] || busy_a[k]) cnt++;
    chk("t4_quiet", cnt, 0);
    pulse_play(1'b0);
    capture(1, CAP);
    check_take("t4_replay");

    // Async reset mid-PRIME
    pulse_play(1'b0);
    chk("t5_in_prime", 32'(en), 32'd1);
    reset = 1'b1;
    #1;
    chk_idle("t5_rst_prime");
    @(negedge clk);
    reset = 1'b0;

    // Async reset mid-PLAY
    pulse_play(1'b0);
    capture(1, 50);
    chk("t5_in_play", 32'(sd), 32'd1);
    reset = 1'b1;
    #1;
    chk_idle("t5_rst_play");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse_play(1'b0);
    capture(1, CAP);
    check_take("t5_after");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
